// File: rtl/nes_pad_responder.sv
`default_nettype none
// ============================================================================
// Module  : nes_pad_responder
// Brief   : NES gamepad (4021-style) emulation; serialises i_buttons on the
//           console's latch/data-clock. Turbo A/B under NES_PAD_TURBO_EN.
// Revision: 1.0 - initial release
// ============================================================================
module nes_pad_responder #(
    parameter int FILTER_CYCLES = 4,
    parameter int CLK_IDLE_HIGH = 1,
    parameter int TURBO_FRAMES  = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_data_latch,
    input  logic       i_data_clock,
    output logic       o_serial_data,
    input  logic [7:0] i_buttons,
    input  logic [1:0] i_turbo,
    output logic       o_latch_seen,
    output logic [3:0] o_bits_read,
    output logic       o_overread
);

    localparam logic [3:0] c_RUN_LAST = 4'(FILTER_CYCLES - 1);
    localparam logic       c_CLK_IDLE = (CLK_IDLE_HIGH != 0);

    logic [1:0] w_pin;
    logic [1:0] w_filt;
    logic [1:0] w_flip;

    assign w_pin = {i_data_clock, i_data_latch};

    // Index 0 = latch, index 1 = data-clock. w_flip marks the cycle the
    // filtered level changes, so edge strobes act without an extra stage.
    generate
        for (genvar g = 0; g < 2; g++) begin : g_cond
            localparam logic c_RST_LVL = (g == 1) ? c_CLK_IDLE : 1'b0;
            logic       r_meta;
            logic       r_sync;
            logic       r_filt;
            logic [3:0] r_run;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_meta <= c_RST_LVL;
                    r_sync <= c_RST_LVL;
                    r_filt <= c_RST_LVL;
                    r_run  <= '0;
                end else begin
                    r_meta <= w_pin[g];
                    r_sync <= r_meta;
                    if (r_sync == r_filt) begin
                        r_run <= '0;
                    end else if (r_run == c_RUN_LAST) begin
                        r_filt <= r_sync;
                        r_run  <= '0;
                    end else begin
                        r_run <= r_run + 4'd1;
                    end
                end
            end

            assign w_filt[g] = r_filt;
            assign w_flip[g] = (r_sync != r_filt) && (r_run == c_RUN_LAST);
        end
    endgenerate

    logic w_latch_rise;
    logic w_latch_fall;
    logic w_shift;
    logic [7:0] w_eff;

    assign w_latch_rise = w_flip[0] & ~w_filt[0];
    assign w_latch_fall = w_flip[0] &  w_filt[0];
    assign w_shift      = w_flip[1] & (w_filt[1] != c_CLK_IDLE);

`ifdef NES_PAD_TURBO_EN
    localparam int c_TW = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;
    logic [c_TW-1:0] r_frame_cnt;
    logic            r_turbo_phase;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_cnt   <= '0;
            r_turbo_phase <= 1'b0;
        end else if (w_latch_fall) begin
            if (r_frame_cnt == c_TW'(TURBO_FRAMES - 1)) begin
                r_frame_cnt   <= '0;
                r_turbo_phase <= ~r_turbo_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign w_eff = {i_buttons[7:2],
                    i_buttons[1] & (~i_turbo[1] | r_turbo_phase),
                    i_buttons[0] & (~i_turbo[0] | r_turbo_phase)};
`else
    logic w_unused_turbo;
    assign w_unused_turbo = ^i_turbo;
    assign w_eff          = i_buttons;
`endif

    logic [7:0] r_sreg;
    logic       r_serial;
    logic [3:0] r_bits;
    logic       r_seen;
    logic       r_over;

    // Latch fall has top priority (keeps last load), then load, then shift.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sreg   <= 8'hFF;
            r_serial <= 1'b1;
            r_bits   <= '0;
            r_seen   <= 1'b0;
            r_over   <= 1'b0;
        end else begin
            r_serial <= r_sreg[0];
            r_seen   <= w_latch_fall;
            r_over   <= 1'b0;
            if (w_latch_fall) begin
                r_bits <= '0;
            end else if (w_filt[0] | w_latch_rise) begin
                r_sreg <= ~w_eff;
            end else if (w_shift) begin
                r_sreg <= {1'b1, r_sreg[7:1]};
                r_over <= (r_bits >= 4'd8);
                if (r_bits != 4'd15) begin
                    r_bits <= r_bits + 4'd1;
                end
            end
        end
    end

    assign o_serial_data = r_serial;
    assign o_latch_seen  = r_seen;
    assign o_bits_read   = r_bits;
    assign o_overread    = r_over;

endmodule
`default_nettype wire

// File: tb/tb_nes_pad_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_nes_pad_responder
// Brief   : Directed self-checking bench for nes_pad_responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_nes_pad_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       latch_pin;
    logic       dclk_pin;
    logic       serial;
    logic [7:0] buttons;
    logic [1:0] turbo;
    logic       latch_seen;
    logic [3:0] bits_read;
    logic       overread;

    int n_checks = 0;
    int n_fail   = 0;
    int n_seen   = 0;
    int n_over   = 0;

    nes_pad_responder dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_data_latch  (latch_pin),
        .i_data_clock  (dclk_pin),
        .o_serial_data (serial),
        .i_buttons     (buttons),
        .i_turbo       (turbo),
        .o_latch_seen  (latch_seen),
        .o_bits_read   (bits_read),
        .o_overread    (overread)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (latch_seen) n_seen++;
        if (overread)   n_over++;
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        latch_pin = 1'b1;
        tick(20);
        latch_pin = 1'b0;
        tick(10);
    endtask

    // Console samples at the end of each low phase, just before the rising edge.
    task automatic read_bits(input int n, output logic [7:0] val);
        val = 8'h00;
        for (int i = 0; i < n; i++) begin
            dclk_pin = 1'b0;
            tick(10);
            val[i] = serial;
            dclk_pin = 1'b1;
            tick(10);
        end
    endtask

    task automatic pulse_low(input int n);
        dclk_pin = 1'b0;
        tick(n);
        dclk_pin = 1'b1;
        tick(10);
    endtask

    logic [7:0] rd;
    int         seen0;
    int         over0;

    initial begin
        rst       = 1'b1;
        latch_pin = 1'b0;
        dclk_pin  = 1'b1;
        buttons   = 8'h09;
        turbo     = 2'b00;
        tick(4);
        check_eq("rst_serial",   8'(serial),     8'h01);
        check_eq("rst_bits",     8'(bits_read),  8'h00);
        check_eq("rst_seen",     8'(latch_seen), 8'h00);
        check_eq("rst_overread", 8'(overread),   8'h00);
        rst = 1'b0;
        tick(5);

        // Basic read of A + Start
        seen0 = n_seen;
        over0 = n_over;
        frame();
        read_bits(8, rd);
        check_eq("basic_byte",  rd,                    8'hF6);
        check_eq("basic_bits",  8'(bits_read),         8'h08);
        check_eq("basic_seen",  8'(n_seen - seen0),    8'h01);
        check_eq("basic_over0", 8'(n_over - over0),    8'h00);

        // Two extra reads past the end
        read_bits(2, rd);
        check_eq("over_data",  rd,                 8'h03);
        check_eq("over_count", 8'(n_over - over0), 8'h02);
        check_eq("over_bits",  8'(bits_read),      8'h0A);

        // Glitch rejection: 2 and 3 cycle lows ignored, 5 accepted
        frame();
        pulse_low(2);
        check_eq("glitch2_bits", 8'(bits_read), 8'h00);
        pulse_low(3);
        check_eq("glitch3_bits", 8'(bits_read), 8'h00);
        check_eq("glitch_data",  8'(serial),    8'h00);
        pulse_low(5);
        check_eq("pulse5_bits",  8'(bits_read), 8'h01);
        check_eq("pulse5_data",  8'(serial),    8'h01);

        // Latch priority: clocks during latch are ignored, load tracks buttons
        buttons   = 8'h00;
        latch_pin = 1'b1;
        tick(10);
        for (int i = 0; i < 3; i++) pulse_low(10);
        buttons = 8'h80;
        for (int i = 0; i < 2; i++) pulse_low(10);
        check_eq("prio_bits_hi", 8'(bits_read), 8'h01);
        latch_pin = 1'b0;
        tick(10);
        check_eq("prio_bits_lo", 8'(bits_read), 8'h00);
        read_bits(8, rd);
        check_eq("prio_byte", rd, 8'h7F);

        // Shift edge coincident with latch fall is ignored
        buttons   = 8'h06;
        seen0     = n_seen;
        latch_pin = 1'b1;
        tick(10);
        dclk_pin = 1'b0;
        tick(10);
        latch_pin = 1'b0;
        dclk_pin  = 1'b1;
        tick(12);
        check_eq("simul_seen", 8'(n_seen - seen0), 8'h01);
        check_eq("simul_bits", 8'(bits_read),      8'h00);
        check_eq("simul_data", 8'(serial),         8'h01);
        read_bits(8, rd);
        check_eq("simul_byte", rd, 8'hF9);

        // Reset mid-frame
        buttons = 8'h5A;
        frame();
        read_bits(3, rd);
        check_eq("mid_bits", 8'(bits_read), 8'h03);
        rst = 1'b1;
        tick(1);
        check_eq("mid_rst_serial", 8'(serial),    8'h01);
        check_eq("mid_rst_bits",   8'(bits_read), 8'h00);
        rst = 1'b0;
        tick(5);
        frame();
        read_bits(8, rd);
        check_eq("post_rst_byte", rd, 8'hA5);

`ifdef NES_PAD_TURBO_EN
        // Turbo on A: released x2, pressed x2, repeating
        rst = 1'b1;
        tick(2);
        rst     = 1'b0;
        buttons = 8'h01;
        turbo   = 2'b01;
        tick(5);
        for (int f = 0; f < 8; f++) begin
            frame();
            check_eq($sformatf("turbo_f%0d", f), 8'(serial), ((f % 4) < 2) ? 8'h01 : 8'h00);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
